// File: rtl/apb4_master.sv
// APB4 requester bridge: runs single-beat register-bus requests as APB4 SETUP/ACCESS transfers.
// Optional ACCESS wait-state abort is enabled by defining APB4_MASTER_TIMEOUT_EN.
module apb4_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [2:0]  PPROT_VAL      = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_bus_req,
  input  logic                    i_bus_req_is_wr,
  input  logic [ADDR_WIDTH-1:0]   i_bus_addr,
  input  logic [DATA_WIDTH-1:0]   i_bus_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_bus_wr_biten,
  output logic                    o_bus_req_stall,
  output logic                    o_bus_rd_ack,
  output logic                    o_bus_wr_ack,
  output logic                    o_bus_rd_err,
  output logic                    o_bus_wr_err,
  output logic [DATA_WIDTH-1:0]   o_bus_rd_data,
  output logic                    o_timeout,
  output logic                    m_apb_psel,
  output logic                    m_apb_penable,
  output logic                    m_apb_pwrite,
  output logic [ADDR_WIDTH-1:0]   m_apb_paddr,
  output logic [DATA_WIDTH-1:0]   m_apb_pwdata,
  output logic [DATA_WIDTH/8-1:0] m_apb_pstrb,
  output logic [2:0]              m_apb_pprot,
  input  logic [DATA_WIDTH-1:0]   m_apb_prdata,
  input  logic                    m_apb_pready,
  input  logic                    m_apb_pslverr
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32) || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("apb4_master: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                  state_q, state_d;
  logic                    timeout_c;
  logic                    psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d, rd_data_q, rd_data_d;
  logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
  logic                    rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;
  logic                    rd_err_q, rd_err_d, wr_err_q, wr_err_d;
  logic                    timeout_q, timeout_d;

`ifdef APB4_MASTER_TIMEOUT_EN
  // Counts ACCESS wait states; abort fires on the TIMEOUT_CYCLES-th consecutive wait.
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == SETUP) begin
      wait_cnt_d = '0;
    end else if (state_q == ACCESS && !m_apb_pready) begin
      wait_cnt_d = wait_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end

  assign timeout_c = (state_q == ACCESS) && !m_apb_pready &&
                     (wait_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_bus_req) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (m_apb_pready || timeout_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered APB and completion outputs.
  always_comb begin
    psel_d    = 1'b0;
    penable_d = 1'b0;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    rd_data_d = rd_data_q;
    rd_ack_d  = 1'b0;
    wr_ack_d  = 1'b0;
    rd_err_d  = 1'b0;
    wr_err_d  = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_bus_req) begin
          psel_d   = 1'b1;
          pwrite_d = i_bus_req_is_wr;
          paddr_d  = i_bus_addr;
          pwdata_d = i_bus_req_is_wr ? i_bus_wr_data : '0;
          pstrb_d  = i_bus_req_is_wr ? i_bus_wr_biten : '0;
        end
      end
      SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (m_apb_pready) begin
          rd_ack_d = !pwrite_q;
          wr_ack_d = pwrite_q;
          rd_err_d = !pwrite_q && m_apb_pslverr;
          wr_err_d = pwrite_q && m_apb_pslverr;
          if (!pwrite_q) rd_data_d = m_apb_pslverr ? '0 : m_apb_prdata;
        end else if (timeout_c) begin
          rd_ack_d  = !pwrite_q;
          wr_ack_d  = pwrite_q;
          rd_err_d  = !pwrite_q;
          wr_err_d  = pwrite_q;
          timeout_d = 1'b1;
          if (!pwrite_q) rd_data_d = '0;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      rd_data_q <= rd_data_d;
      rd_ack_q  <= rd_ack_d;
      wr_ack_q  <= wr_ack_d;
      rd_err_q  <= rd_err_d;
      wr_err_q  <= wr_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_bus_req_stall = (state_q != IDLE);
  assign o_bus_rd_ack    = rd_ack_q;
  assign o_bus_wr_ack    = wr_ack_q;
  assign o_bus_rd_err    = rd_err_q;
  assign o_bus_wr_err    = wr_err_q;
  assign o_bus_rd_data   = rd_data_q;
  assign o_timeout       = timeout_q;
  assign m_apb_psel      = psel_q;
  assign m_apb_penable   = penable_q;
  assign m_apb_pwrite    = pwrite_q;
  assign m_apb_paddr     = paddr_q;
  assign m_apb_pwdata    = pwdata_q;
  assign m_apb_pstrb     = pstrb_q;
  assign m_apb_pprot     = PPROT_VAL;

endmodule

// File: tb/tb_apb4_master.sv
// Self-checking bench for apb4_master: directed vector table, hand-written corner sequences,
// and randomized transfers checked against a transaction-level expectation model.
module tb_apb4_master;

`ifdef APB4_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 4;
  localparam logic [2:0] PROT = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_bus_req, i_bus_req_is_wr;
  logic [31:0] i_bus_addr, i_bus_wr_data;
  logic [3:0]  i_bus_wr_biten;
  logic        o_bus_req_stall, o_bus_rd_ack, o_bus_wr_ack, o_bus_rd_err, o_bus_wr_err, o_timeout;
  logic [31:0] o_bus_rd_data;
  logic        m_apb_psel, m_apb_penable, m_apb_pwrite;
  logic [31:0] m_apb_paddr, m_apb_pwdata, m_apb_prdata;
  logic [3:0]  m_apb_pstrb;
  logic [2:0]  m_apb_pprot;
  logic        m_apb_pready, m_apb_pslverr;

  apb4_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PPROT_VAL(PROT), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_bus_req(i_bus_req), .i_bus_req_is_wr(i_bus_req_is_wr), .i_bus_addr(i_bus_addr),
    .i_bus_wr_data(i_bus_wr_data), .i_bus_wr_biten(i_bus_wr_biten),
    .o_bus_req_stall(o_bus_req_stall), .o_bus_rd_ack(o_bus_rd_ack), .o_bus_wr_ack(o_bus_wr_ack),
    .o_bus_rd_err(o_bus_rd_err), .o_bus_wr_err(o_bus_wr_err), .o_bus_rd_data(o_bus_rd_data),
    .o_timeout(o_timeout),
    .m_apb_psel(m_apb_psel), .m_apb_penable(m_apb_penable), .m_apb_pwrite(m_apb_pwrite),
    .m_apb_paddr(m_apb_paddr), .m_apb_pwdata(m_apb_pwdata), .m_apb_pstrb(m_apb_pstrb),
    .m_apb_pprot(m_apb_pprot), .m_apb_prdata(m_apb_prdata), .m_apb_pready(m_apb_pready),
    .m_apb_pslverr(m_apb_pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  biten;
    int          waits;
    logic [31:0] prdata;
    bit          slverr;
    int          idle_before;
    bit          noise;
  } vec_t;

  typedef struct {
    int          lat;    // cycles from request cycle to ack cycle
    bit          err;
    bit          to;
    logic [31:0] rdata;  // read data after completion (reads only)
  } exp_t;

  typedef struct {
    vec_t v;
    exp_t e;
  } rec_t;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_rd_hold = 32'h0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Transaction-level expectation: latency, error and read data from the transfer's own parameters.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    e.to    = TO_EN && (v.waits >= TO);
    e.lat   = e.to ? (2 + TO) : (3 + v.waits);
    e.err   = e.to ? 1'b1 : v.slverr;
    e.rdata = (e.to || v.slverr) ? 32'h0 : v.prdata;
    return e;
  endfunction

  // Issues one request and plays the APB completer, checking every cycle up to the ack.
  task automatic do_xfer(input vec_t v, input exp_t e, input string tag);
    logic [31:0] x_wdata;
    logic [3:0]  x_strb;
    x_wdata = v.is_wr ? v.wdata : 32'h0;
    x_strb  = v.is_wr ? v.biten : 4'h0;
    for (int i = 0; i < v.idle_before; i++) begin
      i_bus_req = 1'b0;
      @(posedge clk); #1;
      check({tag, "_idle"}, {o_bus_req_stall, m_apb_psel, m_apb_penable, o_bus_rd_ack, o_bus_wr_ack}, 5'b0);
    end
    i_bus_req = 1'b1; i_bus_req_is_wr = v.is_wr; i_bus_addr = v.addr;
    i_bus_wr_data = v.wdata; i_bus_wr_biten = v.biten;
    for (int c = 1; c <= e.lat; c++) begin
      @(posedge clk); #1;
      if (c < e.lat) begin
        check({tag, "_ctl"},
              {m_apb_psel, m_apb_penable, m_apb_pwrite, o_bus_req_stall, o_bus_rd_ack, o_bus_wr_ack, o_timeout},
              {1'b1, 1'(c > 1), v.is_wr, 1'b1, 3'b000});
        check({tag, "_bus"}, {m_apb_paddr, m_apb_pwdata, m_apb_pstrb}, {v.addr, x_wdata, x_strb});
        if (v.noise) begin
          i_bus_req = 1'b1; i_bus_req_is_wr = 1'($urandom);
          i_bus_addr = $urandom; i_bus_wr_data = $urandom; i_bus_wr_biten = 4'($urandom);
        end else begin
          i_bus_req = 1'b0;
        end
        if (c == 1) m_apb_pready = 1'($urandom);
        else        m_apb_pready = (c == e.lat - 1) && !e.to;
        m_apb_prdata  = (m_apb_pready && c > 1) ? v.prdata : $urandom;
        m_apb_pslverr = (m_apb_pready && c > 1) ? v.slverr : 1'($urandom);
      end else begin
        i_bus_req = 1'b0; m_apb_pready = 1'b0;
        check({tag, "_ack"},
              {m_apb_psel, m_apb_penable, m_apb_pwrite, o_bus_req_stall, o_bus_rd_ack, o_bus_wr_ack, o_timeout},
              {1'b0, 1'b0, v.is_wr, 1'b0, !v.is_wr, v.is_wr, e.to});
        check({tag, "_err"}, {o_bus_rd_err, o_bus_wr_err}, {!v.is_wr && e.err, v.is_wr && e.err});
        if (!v.is_wr) exp_rd_hold = e.rdata;
        check({tag, "_rdata"}, o_bus_rd_data, exp_rd_hold);
        check({tag, "_hold"}, {m_apb_paddr, m_apb_pwdata, m_apb_pstrb}, {v.addr, x_wdata, x_strb});
      end
    end
  endtask

  rec_t tbl[7];

  initial begin
    vec_t v;
    exp_t e;

    tbl[0] = '{'{1, 32'h10, 32'hDEADBEEF, 4'b0011, 0, 32'h0, 0, 0, 0}, '{3, 0, 0, 32'h0}};
    tbl[1] = '{'{0, 32'h4, 32'h0, 4'hF, 2, 32'h12345678, 0, 1, 0}, '{5, 0, 0, 32'h12345678}};
    tbl[2] = '{'{0, 32'h8, 32'h0, 4'h0, 0, 32'hAAAA5555, 1, 0, 0}, '{3, 1, 0, 32'h0}};
    tbl[3] = '{'{1, 32'h20, 32'h01020304, 4'b1111, 1, 32'h0, 1, 0, 1}, '{4, 1, 0, 32'h0}};
    tbl[4] = '{'{0, 32'h24, 32'h0, 4'h0, 3, 32'hCAFEF00D, 0, 0, 1}, '{6, 0, 0, 32'hCAFEF00D}};
    tbl[5] = '{'{1, 32'h3C, 32'h55AA55AA, 4'b1000, 0, 32'h0, 0, 0, 0}, '{3, 0, 0, 32'h0}};
    tbl[6] = '{'{0, 32'h40, 32'h0, 4'h0, 1, 32'h00000001, 0, 2, 0}, '{4, 0, 0, 32'h00000001}};

    rst = 1'b1; i_bus_req = 1'b0; i_bus_req_is_wr = 1'b0; i_bus_addr = '0;
    i_bus_wr_data = '0; i_bus_wr_biten = '0;
    m_apb_prdata = '0; m_apb_pready = 1'b0; m_apb_pslverr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl",
          {m_apb_psel, m_apb_penable, m_apb_pwrite, o_bus_req_stall, o_bus_rd_ack, o_bus_wr_ack,
           o_bus_rd_err, o_bus_wr_err, o_timeout}, 9'b0);
    check("reset_data", {m_apb_paddr, m_apb_pwdata, m_apb_pstrb, o_bus_rd_data}, 100'b0);
    check("pprot", m_apb_pprot, PROT);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) do_xfer(tbl[i].v, tbl[i].e, $sformatf("vec%0d", i));

    // Reset in the middle of ACCESS: bus drops, no ack, next transfer is clean.
    i_bus_req = 1'b1; i_bus_req_is_wr = 1'b1; i_bus_addr = 32'h44;
    i_bus_wr_data = 32'h99; i_bus_wr_biten = 4'hF;
    @(posedge clk); #1;
    i_bus_req = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_access", {m_apb_psel, m_apb_penable}, 2'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; m_apb_pready = 1'b1;
    check("rst_mid_ctl", {m_apb_psel, m_apb_penable, o_bus_req_stall, o_bus_rd_ack, o_bus_wr_ack}, 5'b0);
    check("rst_mid_addr", m_apb_paddr, 32'h0);
    exp_rd_hold = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_no_ack", {m_apb_psel, o_bus_rd_ack, o_bus_wr_ack}, 3'b0);
    end
    m_apb_pready = 1'b0;
    v = '{0, 32'h48, 32'h0, 4'h0, 1, 32'h0BADF00D, 0, 0, 0};
    do_xfer(v, model(v), "post_rst");

`ifdef APB4_MASTER_TIMEOUT_EN
    // Completer never ready: abort after TO ACCESS cycles with error and timeout pulse.
    v = '{0, 32'h50, 32'h0, 4'h0, 20, 32'h11111111, 0, 0, 0};
    do_xfer(v, '{2 + TO, 1, 1, 32'h0}, "timeout_rd");
    @(posedge clk); #1;
    check("timeout_pulse_end", {o_timeout, o_bus_rd_ack, m_apb_psel}, 3'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      v.is_wr       = 1'($urandom);
      v.addr        = $urandom;
      v.wdata       = $urandom;
      v.biten       = 4'($urandom);
      v.waits       = $urandom_range(0, 6);
      v.prdata      = $urandom;
      v.slverr      = ($urandom_range(0, 3) == 0);
      v.idle_before = $urandom_range(0, 2);
      v.noise       = 1'($urandom);
      e = model(v);
      do_xfer(v, e, $sformatf("rnd%0d", i));
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
